// File: rtl/fifo_pkg.sv
// Shared FIFO constants: read-mode selectors and a depth helper.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_depth(input int deep);
    return 1 << deep;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo; master drives requests, slave is the FIFO.
interface sync_fifo_if #(
  parameter int N    = 8,
  parameter int DEEP = 4
);
  logic            flush;
  logic [N-1:0]    data_in;
  logic            w_en;
  logic            r_en;
  logic [N-1:0]    data_o;
  logic            Full;
  logic            Empty;
  logic            Almost_full;
  logic            Almost_empty;
  logic [DEEP:0]   count;
  logic            ovf;
  logic            udf;

  modport master (
    output flush, data_in, w_en, r_en,
    input  data_o, Full, Empty, Almost_full, Almost_empty, count, ovf, udf
  );

  modport slave (
    input  flush, data_in, w_en, r_en,
    output data_o, Full, Empty, Almost_full, Almost_empty, count, ovf, udf
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// Register-array storage: synchronous write, asynchronous read.
module sync_fifo_mem #(
  parameter int N    = 8,
  parameter int DEEP = 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [DEEP-1:0] waddr,
  input  logic [N-1:0]    wdata,
  input  logic [DEEP-1:0] raddr,
  output logic [N-1:0]    rdata
);
  import fifo_pkg::*;

  logic [N-1:0] mem [fifo_depth(DEEP)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable thresholds, flush,
// sticky overflow/underflow and selectable standard / first-word-fall-through read.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int N      = 8,
  parameter int DEEP   = 4,
  parameter int FWFT   = 0,
  parameter int AF_LVL = 14,
  parameter int AE_LVL = 2
) (
  input  logic      clk,
  input  logic      arst,
  sync_fifo_if.slave bus
);

  localparam int            DEPTH   = fifo_depth(DEEP);
  localparam logic [DEEP:0] DEPTH_C = (DEEP+1)'(DEPTH);
  localparam logic [DEEP:0] AF_C    = (DEEP+1)'(AF_LVL);
  localparam logic [DEEP:0] AE_C    = (DEEP+1)'(AE_LVL);

  generate
    if (DEEP < 1 || AF_LVL < 1 || AF_LVL > DEPTH || AE_LVL < 0 || AE_LVL >= DEPTH) begin : g_param_check
      $error("sync_fifo: illegal DEEP/AF_LVL/AE_LVL combination");
    end
  endgenerate

  logic [DEEP-1:0] wr_ptr;
  logic [DEEP-1:0] rd_ptr;
  logic [DEEP:0]   count_r;
  logic            ovf_r;
  logic            udf_r;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [N-1:0]    rdata;

  // Every flag is a decode of the count register, so all flags agree on the same edge.
  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == '0);
  assign pop   = bus.r_en & ~empty;
  assign push  = bus.w_en & (~full | pop);

  assign bus.Full         = full;
  assign bus.Empty        = empty;
  assign bus.Almost_full  = (count_r >= AF_C);
  assign bus.Almost_empty = (count_r <= AE_C);
  assign bus.count        = count_r;
  assign bus.ovf          = ovf_r;
  assign bus.udf          = udf_r;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + DEEP'(1);
      if (pop)  rd_ptr <= rd_ptr + DEEP'(1);
      count_r <= count_r + (DEEP+1)'(push) - (DEEP+1)'(pop);
      if (bus.w_en & full & ~pop) ovf_r <= 1'b1;
      if (bus.r_en & empty)       udf_r <= 1'b1;
    end
  end

  sync_fifo_mem #(.N(N), .DEEP(DEEP)) u_mem (
    .clk   (clk),
    .we    (push & ~bus.flush),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  generate
    if (FWFT == FIFO_MODE_STD) begin : g_std
      logic [N-1:0] data_r;
      always_ff @(posedge clk or posedge arst) begin
        if (arst)           data_r <= '0;
        else if (bus.flush) data_r <= '0;
        else if (pop)       data_r <= rdata;
      end
      assign bus.data_o = data_r;
    end else begin : g_fwft
      // Head word is shown directly from the array; r_en only acknowledges it.
      assign bus.data_o = empty ? '0 : rdata;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-read instance and a FWFT instance.
module tb_sync_fifo;
  logic clk;
  logic arst;
  int   n_checks;
  int   n_fail;

  sync_fifo_if #(.N(8), .DEEP(4)) bs ();
  sync_fifo_if #(.N(8), .DEEP(4)) bf ();

  sync_fifo #(.N(8), .DEEP(4), .FWFT(0), .AF_LVL(14), .AE_LVL(2)) u_std (
    .clk (clk), .arst (arst), .bus (bs)
  );
  sync_fifo #(.N(8), .DEEP(4), .FWFT(1), .AF_LVL(14), .AE_LVL(2)) u_fw (
    .clk (clk), .arst (arst), .bus (bf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic std_write(input logic [7:0] d);
    bs.w_en = 1'b1; bs.data_in = d;
    tick();
    bs.w_en = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (bs.count !== 5'd0)  begin n_fail++; $display("FAIL reset_count got %0d exp 0", bs.count); end
    n_checks++; if (bs.Empty !== 1'b1 || bs.Full !== 1'b0) begin n_fail++; $display("FAIL reset_empty_full got E=%b F=%b exp E=1 F=0", bs.Empty, bs.Full); end
    n_checks++; if (bs.Almost_empty !== 1'b1 || bs.Almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost got AE=%b AF=%b exp AE=1 AF=0", bs.Almost_empty, bs.Almost_full); end
    n_checks++; if (bs.data_o !== 8'h00 || bs.ovf !== 1'b0 || bs.udf !== 1'b0) begin n_fail++; $display("FAIL reset_data_err got d=%h o=%b u=%b exp 00 0 0", bs.data_o, bs.ovf, bs.udf); end
    n_checks++; if (bf.data_o !== 8'h00 || bf.Empty !== 1'b1) begin n_fail++; $display("FAIL reset_fwft got d=%h E=%b exp 00 1", bf.data_o, bf.Empty); end
    // build up state: udf set, 6 written, 1 read -> count 5, data_o 0x11
    bs.r_en = 1'b1; tick(); bs.r_en = 1'b0;
    n_checks++; if (bs.udf !== 1'b1) begin n_fail++; $display("FAIL pre_reset_udf got %b exp 1", bs.udf); end
    for (int i = 0; i < 6; i++) std_write(8'h11 + 8'(i));
    bs.r_en = 1'b1; tick(); bs.r_en = 1'b0;
    n_checks++; if (bs.count !== 5'd5 || bs.data_o !== 8'h11) begin n_fail++; $display("FAIL pre_reset_state got cnt=%0d d=%h exp 5 11", bs.count, bs.data_o); end
    #2 arst = 1'b1;
    #1;
    n_checks++; if (bs.count !== 5'd0 || bs.Empty !== 1'b1) begin n_fail++; $display("FAIL async_reset_count got cnt=%0d E=%b exp 0 1", bs.count, bs.Empty); end
    n_checks++; if (bs.data_o !== 8'h00 || bs.ovf !== 1'b0 || bs.udf !== 1'b0) begin n_fail++; $display("FAIL async_reset_data got d=%h o=%b u=%b exp 00 0 0", bs.data_o, bs.ovf, bs.udf); end
    #1 arst = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      std_write(8'(i));
      n_checks++; if (bs.count !== 5'(i+1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, bs.count, i+1); end
      n_checks++; if (bs.Almost_full !== (i+1 >= 14) || bs.Full !== (i+1 == 16)) begin n_fail++; $display("FAIL fill_flags[%0d] got AF=%b F=%b exp AF=%b F=%b", i, bs.Almost_full, bs.Full, (i+1 >= 14), (i+1 == 16)); end
      n_checks++; if (bs.Almost_empty !== (i+1 <= 2) || bs.Empty !== 1'b0) begin n_fail++; $display("FAIL fill_low[%0d] got AE=%b E=%b exp AE=%b E=0", i, bs.Almost_empty, bs.Empty, (i+1 <= 2)); end
    end
    for (int i = 0; i < 16; i++) begin
      bs.r_en = 1'b1; tick();
      n_checks++; if (bs.data_o !== 8'(i) || bs.count !== 5'(15-i)) begin n_fail++; $display("FAIL drain[%0d] got d=%h cnt=%0d exp d=%h cnt=%0d", i, bs.data_o, bs.count, 8'(i), 15-i); end
    end
    bs.r_en = 1'b0;
    n_checks++; if (bs.Empty !== 1'b1 || bs.Full !== 1'b0) begin n_fail++; $display("FAIL drain_empty got E=%b F=%b exp 1 0", bs.Empty, bs.Full); end
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < 16; i++) std_write(8'h20 + 8'(i));
    std_write(8'hAA);
    n_checks++; if (bs.ovf !== 1'b1 || bs.count !== 5'd16 || bs.Full !== 1'b1) begin n_fail++; $display("FAIL ovf_set got o=%b cnt=%0d F=%b exp 1 16 1", bs.ovf, bs.count, bs.Full); end
    n_checks++; if (bs.udf !== 1'b0) begin n_fail++; $display("FAIL ovf_no_udf got %b exp 0", bs.udf); end
    for (int i = 0; i < 16; i++) begin
      bs.r_en = 1'b1; tick();
      n_checks++; if (bs.data_o !== 8'h20 + 8'(i)) begin n_fail++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, bs.data_o, 8'h20 + 8'(i)); end
    end
    tick();
    n_checks++; if (bs.count !== 5'd0 || bs.udf !== 1'b1 || bs.data_o !== 8'h2F) begin n_fail++; $display("FAIL udf_set got cnt=%0d u=%b d=%h exp 0 1 2f", bs.count, bs.udf, bs.data_o); end
    n_checks++; if (bs.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", bs.ovf); end
    bs.r_en = 1'b0;
    bs.flush = 1'b1; tick(); bs.flush = 1'b0;
    n_checks++; if (bs.ovf !== 1'b0 || bs.udf !== 1'b0 || bs.data_o !== 8'h00) begin n_fail++; $display("FAIL flush_clear got o=%b u=%b d=%h exp 0 0 00", bs.ovf, bs.udf, bs.data_o); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) std_write(8'h40 + 8'(i));
    bs.w_en = 1'b1; bs.r_en = 1'b1; bs.data_in = 8'h55;
    tick();
    bs.w_en = 1'b0;
    n_checks++; if (bs.count !== 5'd16 || bs.Full !== 1'b1 || bs.ovf !== 1'b0) begin n_fail++; $display("FAIL full_rw_state got cnt=%0d F=%b o=%b exp 16 1 0", bs.count, bs.Full, bs.ovf); end
    n_checks++; if (bs.data_o !== 8'h40) begin n_fail++; $display("FAIL full_rw_first got %h exp 40", bs.data_o); end
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++; if (bs.data_o !== ((i == 15) ? 8'h55 : 8'h41 + 8'(i))) begin n_fail++; $display("FAIL full_rw_drain[%0d] got %h exp %h", i, bs.data_o, (i == 15) ? 8'h55 : 8'h41 + 8'(i)); end
    end
    bs.r_en = 1'b0;
    n_checks++; if (bs.Empty !== 1'b1) begin n_fail++; $display("FAIL full_rw_empty got %b exp 1", bs.Empty); end
  endtask

  task automatic test_fwft();
    bf.w_en = 1'b1; bf.data_in = 8'h3C; tick(); bf.w_en = 1'b0;
    n_checks++; if (bf.Empty !== 1'b0 || bf.data_o !== 8'h3C) begin n_fail++; $display("FAIL fwft_show got E=%b d=%h exp 0 3c", bf.Empty, bf.data_o); end
    bf.r_en = 1'b1; tick(); bf.r_en = 1'b0;
    n_checks++; if (bf.Empty !== 1'b1 || bf.data_o !== 8'h00) begin n_fail++; $display("FAIL fwft_consume got E=%b d=%h exp 1 00", bf.Empty, bf.data_o); end
    bf.w_en = 1'b1; bf.data_in = 8'h01; tick();
    bf.data_in = 8'h02; tick(); bf.w_en = 1'b0;
    n_checks++; if (bf.data_o !== 8'h01 || bf.count !== 5'd2) begin n_fail++; $display("FAIL fwft_head got d=%h cnt=%0d exp 01 2", bf.data_o, bf.count); end
    bf.r_en = 1'b1; tick(); bf.r_en = 1'b0;
    n_checks++; if (bf.data_o !== 8'h02 || bf.count !== 5'd1) begin n_fail++; $display("FAIL fwft_next got d=%h cnt=%0d exp 02 1", bf.data_o, bf.count); end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] d;
    logic [7:0] exp_d;
    logic       w;
    logic       r;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom_range(0, 255));
      q.push_back(d);
      std_write(d);
    end
    for (int c = 0; c < 40; c++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (q.size() <= 8)  r = 1'b0;
      if (q.size() >= 12) w = 1'b0;
      d = 8'($urandom_range(0, 255));
      bs.w_en = w; bs.r_en = r; bs.data_in = d;
      tick();
      exp_d = 8'h00;
      if (r) exp_d = q.pop_front();
      if (w) q.push_back(d);
      n_checks++; if (bs.count !== 5'(q.size())) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d exp %0d", c, bs.count, q.size()); end
      if (r) begin
        n_checks++; if (bs.data_o !== exp_d) begin n_fail++; $display("FAIL wrap_data[%0d] got %h exp %h", c, bs.data_o, exp_d); end
      end
    end
    bs.w_en = 1'b0; bs.r_en = 1'b0;
    while (q.size() > 0) begin
      exp_d = q.pop_front();
      bs.r_en = 1'b1; tick();
      n_checks++; if (bs.data_o !== exp_d) begin n_fail++; $display("FAIL wrap_tail got %h exp %h", bs.data_o, exp_d); end
    end
    bs.r_en = 1'b0;
    n_checks++; if (bs.Empty !== 1'b1 || bs.udf !== 1'b0) begin n_fail++; $display("FAIL wrap_end got E=%b u=%b exp 1 0", bs.Empty, bs.udf); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    arst = 1'b1;
    bs.flush = 1'b0; bs.w_en = 1'b0; bs.r_en = 1'b0; bs.data_in = 8'h00;
    bf.flush = 1'b0; bf.w_en = 1'b0; bf.r_en = 1'b0; bf.data_in = 8'h00;
    #12;
    arst = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_full_rw();
    test_fwft();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
